// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: round-robin arbiter that shares the SD-card single-block
// read port between NUM_REQ clients. It waits for card initialisation, grants
// one client at a time and issues one read. It returns the word, or an error
// on timeout or loss of initialisation, to the client that holds the grant.
module sd_read_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [31:0]               rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    input  logic                      sd_init_done,
    output logic                      sd_read_start,
    output logic [ADDR_W-1:0]         sd_addr,
    input  logic                      sd_read_done,
    input  logic [31:0]               sd_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        WAIT_INIT,
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESPOND
    } state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [IDX_W-1:0]    gnt_idx_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [31:0]         rsp_data_q;
    logic                rsp_err_q;
    logic                start_q;
    logic [ADDR_W-1:0]   sd_addr_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]    timer_q;

    logic [IDX_W-1:0]    rr_ptr_d;
    logic [CNT_W-1:0]    timer_d;
    logic [IDX_W:0]      pick;
    logic                pick_vld;
    logic [IDX_W-1:0]    pick_idx;

    // Returns {found, index} of the first set request at or after ptr, wrapping.
    // Scanning from the far end down lets the nearest candidate win last.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        int             c;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (r[IDX_W'(c)]) res = {1'b1, IDX_W'(c)};
        end
        return res;
    endfunction

    // Arbitration result, pointer advance after service and timeout counter increment.
    always_comb begin
        pick     = rr_pick(req, rr_ptr_q);
        pick_vld = pick[IDX_W];
        pick_idx = pick[IDX_W-1:0];
        rr_ptr_d = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + IDX_W'(1);
        timer_d  = timer_q + CNT_W'(1);
    end

    // Transaction FSM. All outputs are registered here so that they change only on clock edges.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every
        // branch reads the values from before the edge, whatever the statement order.
        if (reset) begin
            state_q     <= WAIT_INIT;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            start_q     <= 1'b0;
            sd_addr_q   <= '0;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
        end else begin
            // Pulse outputs fall back to zero unless a branch below raises them.
            start_q     <= 1'b0;
            rsp_valid_q <= '0;
            case (state_q)
                WAIT_INIT: begin
                    if (sd_init_done) state_q <= IDLE;
                end
                IDLE: begin
                    if (!sd_init_done) begin
                        state_q <= WAIT_INIT;
                    end else if (pick_vld) begin
                        gnt_q     <= NUM_REQ'(1) << pick_idx;
                        gnt_idx_q <= pick_idx;
                        sd_addr_q <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        start_q   <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    if (!sd_init_done) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= gnt_q;
                        state_q     <= RESPOND;
                    end else begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!sd_init_done) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= gnt_q;
                        state_q     <= RESPOND;
                    end else if (sd_read_done) begin
                        // Completion wins over a timeout that expires in the same cycle.
                        rsp_data_q  <= sd_data;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= gnt_q;
                        state_q     <= RESPOND;
                    end else if (timer_q == CNT_LAST) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= gnt_q;
                        state_q     <= RESPOND;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                RESPOND: begin
                    gnt_q    <= '0;
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= sd_init_done ? IDLE : WAIT_INIT;
                end
                default: state_q <= WAIT_INIT;
            endcase
        end
    end

    assign gnt           = gnt_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign sd_read_start = start_q;
    assign sd_addr       = sd_addr_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sd_read_arbiter.sv
// tb_sd_read_arbiter: directed bench for sd_read_arbiter with three clients and
// a 16-cycle timeout. The stimulus pushes the expected responses into a queue.
// A monitor pops and compares an entry whenever a response pulse appears.
module tb_sd_read_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int TO = 16;

    typedef struct packed {
        logic [N-1:0] v;
        logic [31:0]  d;
        logic         e;
    } rsp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic            rsp_err;
    logic            busy;
    logic            sd_init_done = 1'b0;
    logic            sd_read_start;
    logic [AW-1:0]   sd_addr;
    logic            sd_read_done;
    logic [31:0]     sd_data = '0;
    logic            model_done = 1'b0;
    logic            spur_done = 1'b0;

    rsp_t            exp_q[$];
    rsp_t            mon_e;
    int              checks = 0;
    int              errors = 0;
    int              sd_lat = 0;
    logic            use_fixed = 1'b1;
    logic [31:0]     fixed_word = '0;
    logic [AW-1:0]   last_addr = '0;
    int              start_cnt = 0;
    int              cnt = -1;
    int              cyc;

    assign sd_read_done = model_done | spur_done;

    sd_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .sd_init_done(sd_init_done), .sd_read_start(sd_read_start),
        .sd_addr(sd_addr), .sd_read_done(sd_read_done), .sd_data(sd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input string name);
        logic found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (sd_read_start) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic wait_rsp(input string name, output int cycles);
        logic found = 1'b0;
        cycles = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            cycles++;
            if (|rsp_valid) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    // SD controller model: raises done sd_lat cycles after a start pulse (sd_lat=0: never).
    initial forever begin
        @(negedge clk);
        model_done = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                model_done = 1'b1;
                sd_data    = use_fixed ? fixed_word : (last_addr | 32'hCAFE_0000);
                cnt        = -1;
            end
        end
        if (sd_read_start) begin
            start_cnt++;
            last_addr = sd_addr;
            cnt       = (sd_lat > 0) ? sd_lat : -1;
        end
    end

    // Response monitor: every response pulse must match the oldest expected entry.
    initial forever begin
        @(negedge clk);
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (|rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", rsp_valid);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(mon_e.v));
                check("rsp_data", rsp_data, mon_e.d);
                check("rsp_err", 32'(rsp_err), 32'(mon_e.e));
            end
        end
    end

    initial begin
        // Reset values
        tick(3);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_start", 32'(sd_read_start), 32'd0);
        check("rst_sd_addr", sd_addr, 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // Init gating, then a single read from client 0
        reset = 1'b0;
        req_addr[0 +: AW] = 32'h0000_0010;
        req = 3'b001;
        tick(4);
        check("no_init_gnt", 32'(gnt), 32'd0);
        check("no_init_busy", 32'(busy), 32'd1);
        sd_lat = 5;
        use_fixed = 1'b1;
        fixed_word = 32'hDEAD_BEEF;
        exp_q.push_back('{v: 3'b001, d: 32'hDEAD_BEEF, e: 1'b0});
        sd_init_done = 1'b1;
        tick(1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_gnt", 32'(gnt), 32'd0);
        tick(1);
        check("init_gnt", 32'(gnt), 32'b001);
        check("issue_start", 32'(sd_read_start), 32'd1);
        check("issue_addr", sd_addr, 32'h0000_0010);
        wait_rsp("single_rsp_seen", cyc);
        check("single_latency", cyc, 6);
        req = '0;
        tick(1);
        check("single_idle", 32'(busy), 32'd0);
        check("single_starts", start_cnt, 1);

        // Timeout on client 1: 16 WAIT_DONE cycles, then error response
        sd_lat = 0;
        req_addr[AW +: AW] = 32'h0000_0040;
        exp_q.push_back('{v: 3'b010, d: 32'h0, e: 1'b1});
        req = 3'b010;
        wait_start("to_start_seen");
        check("to_addr", sd_addr, 32'h0000_0040);
        wait_rsp("to_rsp_seen", cyc);
        check("to_latency", cyc, 17);
        req = '0;
        tick(1);
        check("to_idle", 32'(busy), 32'd0);

        // Done on the timeout cycle wins: client 2
        sd_lat = 16;
        fixed_word = 32'h1234_5678;
        req_addr[2*AW +: AW] = 32'h0000_0080;
        exp_q.push_back('{v: 3'b100, d: 32'h1234_5678, e: 1'b0});
        req = 3'b100;
        wait_start("edge_start_seen");
        wait_rsp("edge_rsp_seen", cyc);
        check("edge_latency", cyc, 17);
        req = '0;

        // Spurious done while idle
        tick(1);
        spur_done = 1'b1;
        tick(2);
        spur_done = 1'b0;
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_gnt", 32'(gnt), 32'd0);

        // Fairness: all three clients held, order 0,1,2,0,1,2
        use_fixed = 1'b0;
        sd_lat = 1;
        req_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back('{v: 3'b001, d: 32'hCAFE_0100, e: 1'b0});
            exp_q.push_back('{v: 3'b010, d: 32'hCAFE_0200, e: 1'b0});
            exp_q.push_back('{v: 3'b100, d: 32'hCAFE_0300, e: 1'b0});
        end
        req = 3'b111;
        for (int r = 0; r < 6; r++) wait_rsp("fair_rsp_seen", cyc);
        req = '0;

        // Reset in WAIT_DONE: silent abort, outputs return to reset values
        sd_lat = 0;
        req = 3'b010;
        wait_start("rst_ab_start_seen");
        tick(3);
        reset = 1'b1;
        req = '0;
        tick(2);
        check("ab_gnt", 32'(gnt), 32'd0);
        check("ab_rsp_valid", 32'(rsp_valid), 32'd0);
        check("ab_rsp_err", 32'(rsp_err), 32'd0);
        check("ab_rsp_data", rsp_data, 32'd0);
        check("ab_start", 32'(sd_read_start), 32'd0);
        check("ab_sd_addr", sd_addr, 32'd0);
        check("ab_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        tick(2);
        check("ab_idle", 32'(busy), 32'd0);

        // Init lost in WAIT_DONE: error response, then WAIT_INIT with req still held
        req_addr[0 +: AW] = 32'h0000_0020;
        exp_q.push_back('{v: 3'b001, d: 32'h0, e: 1'b1});
        req = 3'b001;
        wait_start("il_start_seen");
        check("il_addr", sd_addr, 32'h0000_0020);
        tick(3);
        sd_init_done = 1'b0;
        wait_rsp("il_rsp_seen", cyc);
        check("il_latency", cyc, 1);
        tick(3);
        check("il_wait_busy", 32'(busy), 32'd1);
        check("il_wait_gnt", 32'(gnt), 32'd0);
        req = '0;
        sd_init_done = 1'b1;
        tick(2);
        check("il_idle", 32'(busy), 32'd0);

        tick(2);
        check("total_starts", start_cnt, 11);
        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
